// File: rtl/dm_responder_pkg.sv
// dm_responder_pkg: shared pipeline types, defaults and address checking for the data-memory responder
package dm_responder_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam int DM_DEPTH_WORDS = 3072;
  localparam int DM_LATENCY = 2;
  function automatic logic addr_err(input logic [31:0] a, input int depth);
    return (a[1:0] != 2'b00) || (a[31:2] >= 30'(depth));
  endfunction
endpackage

// File: rtl/dm_array.sv
// dm_array: byte-enabled word storage, cleared on reset, combinational read port
module dm_array import dm_responder_pkg::*; #(
  parameter int DEPTH_WORDS = DM_DEPTH_WORDS,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] widx,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] ridx,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < 4; b++) if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end
  assign rdata = mem[ridx];
endmodule

// File: rtl/dm_responder.sv
// dm_responder: single-outstanding request/response front end with fixed latency over dm_array
module dm_responder import dm_responder_pkg::*; #(
  parameter int DEPTH_WORDS = DM_DEPTH_WORDS,
  parameter int LATENCY = DM_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_t state, state_n;
  logic [3:0] cnt;
  logic we_q;
  logic [3:0] be_q;
  logic [31:0] addr_q, wdata_q;
  logic acc, fire, a_we, a_err;
  logic [3:0] a_be;
  logic [31:0] a_addr, a_wdata, rdata;
  logic [AW-1:0] idx;
  always_comb begin
    acc = state == IDLE && req_valid;
    fire = (acc && LATENCY == 1) || (state == BUSY && cnt == 4'd1);
    a_we = state == IDLE ? req_we : we_q;
    a_be = state == IDLE ? req_be : be_q;
    a_addr = state == IDLE ? req_addr : addr_q;
    a_wdata = state == IDLE ? req_wdata : wdata_q;
    a_err = addr_err(a_addr, DEPTH_WORDS);
    idx = a_err ? '0 : a_addr[AW+1:2];
    state_n = state == IDLE ? (acc ? (LATENCY == 1 ? RESP : BUSY) : IDLE)
            : state == BUSY ? (cnt == 4'd1 ? RESP : BUSY)
            : (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      we_q <= 1'b0;
      be_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= acc ? 4'(LATENCY - 1) : state == BUSY ? cnt - 4'd1 : cnt;
      if (acc) begin
        we_q <= req_we;
        be_q <= req_be;
        addr_q <= req_addr;
        wdata_q <= req_wdata;
      end
      if (fire) begin
        rsp_rdata <= (a_we || a_err) ? '0 : rdata;
        rsp_err <= a_err;
      end else if (state == RESP && rsp_ready) begin
        rsp_rdata <= '0;
        rsp_err <= 1'b0;
      end
    end
  end
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  dm_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk(clk), .reset(reset), .we(fire && a_we && !a_err), .be(a_be),
    .widx(idx), .wdata(a_wdata), .ridx(idx), .rdata(rdata)
  );
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: randomized and directed checks of dm_responder against a word-map reference model
module tb_dm_responder;
  localparam int LAT = 2;
  localparam int DEPTH = 3072;
  logic clk = 0, reset = 0;
  logic req_valid = 0, req_we = 0, rsp_ready = 0;
  logic [3:0] req_be = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic b_req_valid = 0, b_req_we = 0, b_rsp_ready = 0;
  logic [3:0] b_req_be = 0;
  logic [31:0] b_req_addr = 0, b_req_wdata = 0;
  logic b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;
  int n_cmp = 0, n_bad = 0;
  bit [31:0] mem_m [int];

  dm_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );
  dm_responder #(.DEPTH_WORDS(16), .LATENCY(1)) u_fast (
    .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_be(b_req_be), .req_addr(b_req_addr), .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid),
    .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit [32:0] model_op(input bit we, input bit [3:0] be, input bit [31:0] a, input bit [31:0] wd);
    int idx;
    idx = int'(a >> 2);
    if (a[1:0] != 0 || (a >> 2) >= DEPTH) return {1'b1, 32'h0};
    if (!mem_m.exists(idx)) mem_m[idx] = 0;
    if (we) begin
      for (int b = 0; b < 4; b++) if (be[b]) mem_m[idx][8*b +: 8] = wd[8*b +: 8];
      return 33'h0;
    end
    return {1'b0, mem_m[idx]};
  endfunction

  task automatic wait_rsp(input int start, output int n);
    n = start;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic txn(input bit we, input bit [3:0] be, input bit [31:0] addr, input bit [31:0] wd,
                     input int dly, input bit hold, output bit [31:0] rd, output bit er);
    bit [32:0] exp;
    int n;
    exp = model_op(we, be, addr, wd);
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_ready_before", req_ready, 1);
    req_valid = 1; req_we = we; req_be = be; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = hold;
    req_we = hold ? 1'b0 : 1'($urandom);
    req_be = 4'($urandom);
    req_addr = hold ? 32'h10 : {$urandom} & 32'h3C;
    req_wdata = $urandom;
    wait_rsp(1, n);
    chk("latency", n, LAT);
    rd = rsp_rdata; er = rsp_err;
    chk("rsp", {er, rd}, exp);
    for (int i = 0; i < dly; i++) begin
      @(posedge clk); #1;
      chk("hold", {rsp_valid, req_ready, rsp_err, rsp_rdata}, {2'b10, er, rd});
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    chk("idle", {rsp_valid, req_ready, rsp_err, rsp_rdata}, {2'b01, 33'h0});
    if (hold) begin
      exp = model_op(0, 0, 32'h10, 0);
      @(posedge clk); #1;
      req_valid = 0;
      chk("held_accept", {rsp_valid, req_ready}, 2'b00);
      wait_rsp(1, n);
      chk("held_latency", n, LAT);
      chk("held_rsp", {rsp_err, rsp_rdata}, exp);
      rsp_ready = 1;
      @(posedge clk); #1;
      rsp_ready = 0;
      chk("held_idle", {rsp_valid, req_ready}, 2'b01);
    end
  endtask

  initial begin
    bit [31:0] rd, a;
    bit er;
    bit [32:0] e;
    int r;
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", {rsp_valid, req_ready, rsp_err, rsp_rdata}, {2'b01, 33'h0});
    reset = 1;
    txn(1, 4'hF, 32'h10, 32'hDEADBEEF, 0, 0, rd, er);
    chk("w10_err", er, 0);
    txn(0, 4'h0, 32'h10, 0, 0, 0, rd, er);
    chk("r10", {er, rd}, {1'b0, 32'hDEADBEEF});
    txn(1, 4'hF, 32'h20, 32'h11223344, 1, 0, rd, er);
    txn(1, 4'b0101, 32'h20, 32'hAABBCCDD, 0, 0, rd, er);
    txn(0, 4'h0, 32'h20, 0, 2, 0, rd, er);
    chk("r20_merge", {er, rd}, {1'b0, 32'h11BB33DD});
    txn(0, 4'h0, 32'h12, 0, 0, 0, rd, er);
    chk("misaligned", {er, rd}, {1'b1, 32'h0});
    txn(0, 4'h0, 32'h3000, 0, 0, 0, rd, er);
    chk("out_of_range", {er, rd}, {1'b1, 32'h0});
    txn(1, 4'hF, 32'h3000, 32'h12345678, 0, 0, rd, er);
    chk("oor_write", er, 1);
    txn(1, 4'h0, 32'h10, 32'h0, 0, 0, rd, er);
    txn(0, 4'h0, 32'h10, 0, 0, 0, rd, er);
    chk("r10_unchanged", {er, rd}, {1'b0, 32'hDEADBEEF});
    txn(0, 4'h0, 32'h2FFC, 0, 0, 0, rd, er);
    chk("last_word", er, 0);
    txn(0, 4'h0, 32'h20, 0, 5, 1, rd, er);
    req_valid = 1; req_we = 1; req_be = 4'hF; req_addr = 32'h40; req_wdata = 32'h55555555;
    @(posedge clk); #1;
    req_valid = 0;
    chk("busy", {rsp_valid, req_ready}, 2'b00);
    reset = 0;
    @(posedge clk); #1;
    chk("reset_busy", {rsp_valid, req_ready, rsp_err, rsp_rdata}, {2'b01, 33'h0});
    reset = 1;
    mem_m.delete();
    txn(0, 4'h0, 32'h40, 0, 0, 0, rd, er);
    chk("r40_after_reset", {er, rd}, 33'h0);
    txn(0, 4'h0, 32'h10, 0, 0, 0, rd, er);
    chk("r10_cleared", {er, rd}, 33'h0);
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      a = r < 8 ? 32'(4 * r) : r == 8 ? 32'h2FFC : ($urandom_range(0, 1) ? 32'h3000 + 32'(4 * $urandom_range(0, 3)) : 32'(4 * $urandom_range(0, 7) + $urandom_range(1, 3)));
      txn(1'($urandom), 4'($urandom), a, $urandom, $urandom_range(0, 3), 0, rd, er);
    end
    b_rsp_ready = 1;
    b_req_valid = 1;
    for (int k = 0; k < 8; k++) begin
      b_req_we = k < 4;
      b_req_be = 4'hF;
      b_req_addr = 32'(4 * (k % 4));
      b_req_wdata = 32'h1000 + 32'(k);
      e = k < 4 ? 33'h0 : {1'b0, 32'h1000 + 32'(k - 4)};
      chk("fast_ready", {b_rsp_valid, b_req_ready}, 2'b01);
      @(posedge clk); #1;
      chk("fast_rsp", {b_rsp_valid, b_req_ready, b_rsp_err, b_rsp_rdata}, {2'b10, e});
      @(posedge clk); #1;
    end
    b_req_valid = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 3072, meaning number of 32-bit words stored (byte range 0x0000-0x2FFF).
REQ-002 SHALL have parameter LATENCY, default 2, meaning clock edges from request accept to response valid; legal range 1-15.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (reset==0 sampled at a rising edge resets the block).
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_we  input  1  1=write, 0=read.
REQ-008 SHALL have port req_be  input  4  byte enables for writes, bit i selects data[8i+7:8i].
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  write data.
REQ-011 SHALL have port rsp_valid  output  1  response present.
REQ-012 SHALL have port rsp_ready  input  1  initiator consumes response.
REQ-013 SHALL have port rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-014 SHALL have port rsp_err  output  1  request was misaligned or out of range.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, RESP; exactly one outstanding request.
REQ-016 SHALL drive req_ready=1 only in IDLE; a request is accepted at an edge where state==IDLE and req_valid==1.
REQ-017 SHALL capture we, be, addr and wdata at the accept edge; later changes on req_* SHALL have no effect.
REQ-018 SHALL load a down-counter with LATENCY-1 on accept, go to BUSY if that value is nonzero, otherwise go directly to RESP.
REQ-019 SHALL decrement the counter once per edge in BUSY and go to RESP at the edge where it reaches 0; for LATENCY=L, rsp_valid rises immediately after the L-th edge, counting the accept edge as edge 1.
REQ-020 SHALL perform the storage access (read sample or byte-enabled write commit) on the edge that enters RESP.
REQ-021 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until an edge with rsp_ready==1, then go to IDLE; there is no same-cycle turnaround (req_ready rises the cycle after the response handshake).
REQ-022 SHALL flag an error when addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS; an erroring request SHALL NOT modify storage and SHALL return rdata=0, err=1.
REQ-023 SHALL index storage with addr[31:2]; a write with be=4'b0000 SHALL complete normally and leave storage unchanged.
REQ-024 SHALL return, for a read following a write to the same word, the post-write value.
REQ-025 SHALL keep rsp_valid=0 outside RESP and rsp_rdata/rsp_err at 0 outside RESP.

Reset
REQ-026 SHALL, on reset==0, set state=IDLE, counter=0, req_ready=1 (from the cycle after reset deasserts), rsp_valid=0, rsp_rdata=0, rsp_err=0, regardless of current state.
REQ-027 SHALL clear every storage word to 0 on reset, matching the pipeline's data memory clear semantics.
REQ-028 SHALL abandon an in-flight request on reset; a write not yet committed SHALL NOT be performed.

Structure
REQ-029 SHALL take the FSM state enumeration, DEPTH_WORDS default and LATENCY default from the shared pipeline package.
REQ-030 SHALL place the byte-enabled storage array in one sub-module, dm_array (ports: clk, reset, we, be, widx, wdata, ridx, rdata), with FSM and handshake in dm_responder.

Verification
REQ-031 SHALL verify: reset, then write addr=0x10, be=1111, wdata=0xDEADBEEF, LATENCY=2 -> rsp_valid rises 2 edges after accept, err=0; read 0x10 -> rdata=0xDEADBEEF.
REQ-032 SHALL verify: word 0x20 holds 0x11223344; write be=0101, wdata=0xAABBCCDD -> read returns 0x11BB33DD.
REQ-033 SHALL verify: read addr=0x12 and read addr=0x3000 -> each gives err=1, rdata=0; subsequent read of 0x10 unchanged.
REQ-034 SHALL verify: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stable, req_ready=0; req_valid held high is accepted only the cycle after rsp_ready=1.
REQ-035 SHALL verify: reset==0 asserted while BUSY on a write to 0x40 -> outputs return to reset values, read 0x40 returns 0.
REQ-036 SHALL verify: LATENCY=1 back-to-back reads with rsp_ready=1 -> one response every 2 cycles, each valid the cycle after its accept.
